// File: rtl/guess_game_fsm.sv
// Rotating-lamp reaction game: one lamp walks across W positions on en ticks.
// A correct press scores and speeds the walk up; a wrong press resets the speed.
module guess_game_fsm #(
    parameter int W    = 4,
    parameter int N    = 4,
    parameter int HOLD = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] b,
    output logic [W-1:0] y,
    output logic         win,
    output logic         lose,
    output logic [7:0]   score,
    output logic [N-1:0] level
);

    localparam int PW = (W > 1) ? $clog2(W) : 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WIN  = 2'd1;
    localparam logic [1:0] S_LOSE = 2'd2;
    localparam logic [1:0] S_REL  = 2'd3;

    localparam logic [PW-1:0] POS_LAST  = PW'(W - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    // Level tops out one short of all-ones so the reload never drops below 1.
    localparam logic [N-1:0]  LEVEL_MAX = ~N'(1);

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [N-1:0]  dwell_q, dwell_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [N-1:0]  level_q, level_d;
    logic [7:0]    score_q, score_d;
    logic [W-1:0]  b_prev_q, b_prev_d;

    logic [W-1:0]  lit;
    logic [W-1:0]  press;
    logic          press_any;
    logic          press_hit;
    logic [N-1:0]  reload;

    assign lit       = W'(1) << pos_q;
    assign press     = b & ~b_prev_q;
    assign press_any = |press;
    assign press_hit = (b == lit);
    // (2^N - 1) - level is simply the bitwise complement in N bits.
    assign reload    = ~level_q;

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        dwell_d  = dwell_q;
        hold_d   = hold_q;
        level_d  = level_q;
        score_d  = score_q;
        b_prev_d = b;

        case (state_q)
            S_RUN: begin
                // A press outranks a coincident advance tick and is judged on the current lamp.
                if (press_any) begin
                    hold_d = '0;
                    if (press_hit) begin
                        state_d = S_WIN;
                        if (score_q != 8'hFF) begin
                            score_d = score_q + 8'd1;
                        end
                        if (level_q != LEVEL_MAX) begin
                            level_d = level_q + N'(1);
                        end
                    end else begin
                        state_d = S_LOSE;
                        level_d = '0;
                    end
                end else if (en) begin
                    if (dwell_q == '0) begin
                        pos_d   = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
                        dwell_d = reload;
                    end else begin
                        dwell_d = dwell_q - N'(1);
                    end
                end
            end

            S_WIN, S_LOSE: begin
                if (en) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = S_REL;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end

            S_REL: begin
                // Wait for every button to be released so a held button cannot score on re-entry.
                if (b == '0) begin
                    state_d = S_RUN;
                    pos_d   = '0;
                    dwell_d = reload;
                end
            end

            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_RUN;
            pos_q    <= '0;
            dwell_q  <= '1;
            hold_q   <= '0;
            level_q  <= '0;
            score_q  <= '0;
            b_prev_q <= '0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            dwell_q  <= dwell_d;
            hold_q   <= hold_d;
            level_q  <= level_d;
            score_q  <= score_d;
            b_prev_q <= b_prev_d;
        end
    end

    always_comb begin
        y = '0;
        case (state_q)
            S_RUN:   y = lit;
            S_WIN:   y = '1;
            default: y = '0;
        endcase
    end

    assign win   = (state_q == S_WIN);
    assign lose  = (state_q == S_LOSE);
    assign score = score_q;
    assign level = level_q;

endmodule
